// File: rtl/adc_sample_conditioner.sv
// XADC result conditioning: offset binary to two's complement, box-car average and
// decimate by 2^DEC_LOG2, then buffer in a show-ahead FIFO toward the FIR filter.
module adc_sample_conditioner #(
    parameter int DEC_LOG2   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_78MHz_i,
    input  logic                        reset_i,
    input  logic [15:0]                 adc_data_i,
    input  logic                        adc_ready_i,
    input  logic                        fir_ready_i,
    input  logic                        clear_i,
    output logic signed [11:0]          sample_o,
    output logic                        valid_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        overflow_o
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int ACC_W = 12 + DEC_LOG2;
    localparam int PH_W  = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DEC_LOG2) - 1);

    logic signed [11:0]      x_q;
    logic                    cap_q;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum_w;
    logic [PH_W-1:0]         ph_q, ph_d;
    logic                    push_w;
    logic [11:0]             push_data_w;

    logic [11:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q, rd_next_w;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    full_w, pop_w, wr_en_w, drop_w, ovf_q;
    logic [11:0]             head_q, head_d;

    logic                    unused_nibble;
    assign unused_nibble = ^adc_data_i[3:0];

    always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
        if (!reset_i) begin
            x_q   <= '0;
            cap_q <= 1'b0;
        end else begin
            cap_q <= adc_ready_i;
            if (adc_ready_i) begin
                x_q <= {~adc_data_i[15], adc_data_i[14:4]};
            end
        end
    end

    // The final sample of a group is folded in combinationally so the group
    // result leaves on the same edge the accumulator is cleared.
    always_comb begin
        sum_w       = acc_q + ACC_W'(x_q);
        push_data_w = 12'(sum_w >>> DEC_LOG2);
        push_w      = cap_q && (ph_q == PH_LAST);
        acc_d       = acc_q;
        ph_d        = ph_q;
        if (cap_q) begin
            if (ph_q == PH_LAST) begin
                acc_d = '0;
                ph_d  = '0;
            end else begin
                acc_d = sum_w;
                ph_d  = ph_q + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_q <= '0;
            ph_q  <= '0;
        end else begin
            acc_q <= acc_d;
            ph_q  <= ph_d;
        end
    end

    always_comb begin
        full_w    = (cnt_q == CW'(FIFO_DEPTH));
        pop_w     = (cnt_q != '0) && fir_ready_i;
        wr_en_w   = push_w && (!full_w || pop_w);
        drop_w    = push_w && full_w && !pop_w;
        rd_next_w = pop_w ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d     = cnt_q;
        if (wr_en_w && !pop_w) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_en_w && pop_w) begin
            cnt_d = cnt_q - CW'(1);
        end
        // Head register: the entry being written becomes head only when it lands on rd_next.
        head_d = head_q;
        if (cnt_d != '0) begin
            if (wr_en_w && (wr_ptr_q == rd_next_w)) begin
                head_d = push_data_w;
            end else begin
                head_d = mem_q[rd_next_w];
            end
        end
    end

    always_ff @(posedge clk_78MHz_i) begin
        if (wr_en_w) begin
            mem_q[wr_ptr_q] <= push_data_w;
        end
    end

    always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en_w) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_next_w;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            if (drop_w) begin
                ovf_q <= 1'b1;
            end else if (clear_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign sample_o   = head_q;
    assign valid_o    = (cnt_q != '0);
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner: one instance without decimation, one averaging by 4,
// compared against a queue-based model plus directed corner-case sequences.
module tb_adc_sample_conditioner;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] d0_data, d2_data;
    logic        d0_rdy, d2_rdy, d0_fr, d2_fr, d0_clr, d2_clr;
    logic [11:0] d0_sample, d2_sample;
    logic        d0_valid, d2_valid, d0_ovf, d2_ovf;
    logic [2:0]  d0_count, d2_count;
    bit          chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    adc_sample_conditioner #(.DEC_LOG2(0), .FIFO_DEPTH(DEPTH)) u_d0 (
        .clk_78MHz_i(clk), .reset_i(rst_n), .adc_data_i(d0_data), .adc_ready_i(d0_rdy),
        .fir_ready_i(d0_fr), .clear_i(d0_clr), .sample_o(d0_sample), .valid_o(d0_valid),
        .count_o(d0_count), .overflow_o(d0_ovf));

    adc_sample_conditioner #(.DEC_LOG2(2), .FIFO_DEPTH(DEPTH)) u_d2 (
        .clk_78MHz_i(clk), .reset_i(rst_n), .adc_data_i(d2_data), .adc_ready_i(d2_rdy),
        .fir_ready_i(d2_fr), .clear_i(d2_clr), .sample_o(d2_sample), .valid_o(d2_valid),
        .count_o(d2_count), .overflow_o(d2_ovf));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [11:0] exp;
    } cv_t;

    typedef struct packed {
        logic [3:0][15:0] d;
        logic [11:0]      exp;
    } av_t;

    function automatic cv_t mk_cv(input logic [15:0] data, input logic [11:0] exp);
        cv_t r;
        r.data = data;
        r.exp  = exp;
        return r;
    endfunction

    function automatic av_t mk_av(input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] c, input logic [15:0] e,
                                  input logic [11:0] exp);
        av_t r;
        r.d[0] = a;
        r.d[1] = b;
        r.d[2] = c;
        r.d[3] = e;
        r.exp  = exp;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: decoded samples are summed per group, averaged with floor
    // division, and the result is offered to a queue one edge after the capture edge.
    int mq[2][$];
    int gsum[2], gcnt[2], pval[2];
    bit pend[2], movf[2];

    function automatic int floor_div(input int a, input int n);
        int q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset;
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            gsum[k] = 0;
            gcnt[k] = 0;
            pval[k] = 0;
            pend[k] = 1'b0;
            movf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input int dec, input bit rdy,
                              input logic [15:0] data, input bit fr, input bit clr);
        int n;
        int x;
        bit full, pop, drop;
        n    = 1 << dec;
        full = (mq[k].size() == DEPTH);
        pop  = (mq[k].size() != 0) && fr;
        drop = pend[k] && full && !pop;
        if (pop) void'(mq[k].pop_front());
        if (pend[k] && !drop) mq[k].push_back(pval[k]);
        if (drop) movf[k] = 1'b1;
        else if (clr) movf[k] = 1'b0;
        pend[k] = 1'b0;
        if (rdy) begin
            x = int'(data[15:4]) - 2048;
            gsum[k] += x;
            gcnt[k]++;
            if (gcnt[k] == n) begin
                pend[k] = 1'b1;
                pval[k] = floor_div(gsum[k], n);
                gsum[k] = 0;
                gcnt[k] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, 0, d0_rdy, d0_data, d0_fr, d0_clr);
            model_step(1, 2, d2_rdy, d2_data, d2_fr, d2_clr);
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("m_valid0", int'(d0_valid), int'(mq[0].size() != 0));
            chk("m_count0", int'(d0_count), mq[0].size());
            chk("m_ovf0", int'(d0_ovf), int'(movf[0]));
            if (mq[0].size() != 0) chk("m_sample0", int'(d0_sample), mq[0][0] & 'hFFF);
            chk("m_valid2", int'(d2_valid), int'(mq[1].size() != 0));
            chk("m_count2", int'(d2_count), mq[1].size());
            chk("m_ovf2", int'(d2_ovf), int'(movf[1]));
            if (mq[1].size() != 0) chk("m_sample2", int'(d2_sample), mq[1][0] & 'hFFF);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_sample0"}, int'(d0_sample), 0);
        chk({tag, "_valid0"}, int'(d0_valid), 0);
        chk({tag, "_count0"}, int'(d0_count), 0);
        chk({tag, "_ovf0"}, int'(d0_ovf), 0);
        chk({tag, "_sample2"}, int'(d2_sample), 0);
        chk({tag, "_valid2"}, int'(d2_valid), 0);
        chk({tag, "_count2"}, int'(d2_count), 0);
        chk({tag, "_ovf2"}, int'(d2_ovf), 0);
    endtask

    task automatic d0_burst(input int first_x, input int n);
        for (int i = 0; i < n; i++) begin
            d0_data = 16'h8000 + 16'((first_x + i) << 4);
            d0_rdy  = 1'b1;
            tick();
        end
        d0_rdy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    cv_t cv[6];
    av_t av[6];

    initial begin
        cv[0] = mk_cv(16'h0000, 12'h800);
        cv[1] = mk_cv(16'h8000, 12'h000);
        cv[2] = mk_cv(16'hFFFF, 12'h7FF);
        cv[3] = mk_cv(16'h7FF0, 12'hFFF);
        cv[4] = mk_cv(16'h801F, 12'h001);
        cv[5] = mk_cv(16'h4000, 12'hC00);
        av[0] = mk_av(16'h800F, 16'h801A, 16'h802F, 16'h8035, 12'h001);
        av[1] = mk_av(16'h7FF0, 16'h7FF0, 16'h7FF0, 16'h7FE0, 12'hFFE);
        av[2] = mk_av(16'h0000, 16'h0000, 16'h0000, 16'h0000, 12'h800);
        av[3] = mk_av(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 12'h7FF);
        av[4] = mk_av(16'h8050, 16'h7FD0, 16'h8000, 16'h8010, 12'h000);
        av[5] = mk_av(16'h7FF0, 16'h8000, 16'h8000, 16'h8000, 12'hFFF);

        rst_n = 1'b0;
        d0_data = '0; d0_rdy = 1'b0; d0_fr = 1'b1; d0_clr = 1'b0;
        d2_data = '0; d2_rdy = 1'b0; d2_fr = 1'b1; d2_clr = 1'b0;
        model_reset();
        #3;
        chk_zero("rst0");
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Code conversion and 2-cycle latency, no decimation
        for (int i = 0; i < 6; i++) begin
            d0_data = cv[i].data;
            d0_rdy  = 1'b1;
            chk("cv_valid_t0", int'(d0_valid), 0);
            tick();
            d0_rdy = 1'b0;
            chk("cv_valid_t1", int'(d0_valid), 0);
            tick();
            chk("cv_valid_t2", int'(d0_valid), 1);
            chk("cv_sample", int'(d0_sample), int'(cv[i].exp));
            tick();
        end

        // Averaging by 4, one group at a time
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) begin
                d2_data = av[i].d[j];
                d2_rdy  = 1'b1;
                if (j < 3) tick();
            end
            tick();
            d2_rdy = 1'b0;
            chk("av_valid_t1", int'(d2_valid), 0);
            tick();
            chk("av_valid_t2", int'(d2_valid), 1);
            chk("av_sample", int'(d2_sample), int'(av[i].exp));
            tick();
        end

        // Two groups back to back without gaps
        d2_fr = 1'b0;
        for (int g = 0; g < 2; g++) begin
            for (int j = 0; j < 4; j++) begin
                d2_data = av[g].d[j];
                d2_rdy  = 1'b1;
                if (!(g == 1 && j == 3)) tick();
            end
        end
        tick();
        d2_rdy = 1'b0;
        tick();
        chk("b2b_count", int'(d2_count), 2);
        chk("b2b_first", int'(d2_sample), int'(av[0].exp));
        d2_fr = 1'b1;
        tick();
        chk("b2b_second", int'(d2_sample), int'(av[1].exp));
        tick();
        d2_fr = 1'b0;
        chk("b2b_drained", int'(d2_count), 0);

        // Backpressure and overflow: 5 pushes into a 4-deep FIFO
        d0_fr = 1'b0;
        d0_burst(1, 5);
        tick();
        chk("ovf_count", int'(d0_count), 4);
        chk("ovf_flag", int'(d0_ovf), 1);
        d0_fr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_sample", int'(d0_sample), i + 1);
            chk("drain_count", int'(d0_count), 4 - i);
            tick();
        end
        chk("drain_empty", int'(d0_valid), 0);
        chk("drain_count0", int'(d0_count), 0);
        d0_fr = 1'b0;

        // Sticky clear
        d0_clr = 1'b1;
        chk("clr_still_set", int'(d0_ovf), 1);
        tick();
        d0_clr = 1'b0;
        chk("clr_cleared", int'(d0_ovf), 0);

        // Full FIFO with push and pop on the same edge
        d0_burst(10, 5);
        d0_fr = 1'b1;
        tick();
        d0_fr = 1'b0;
        chk("pp_count", int'(d0_count), 4);
        chk("pp_ovf", int'(d0_ovf), 0);
        chk("pp_head", int'(d0_sample), 11);
        d0_fr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_order", int'(d0_sample), 11 + i);
            tick();
        end
        chk("pp_empty", int'(d0_count), 0);
        d0_fr = 1'b0;

        // Clear on the same edge as a drop: set wins
        d0_burst(20, 5);
        d0_clr = 1'b1;
        tick();
        d0_clr = 1'b0;
        chk("clrdrop_ovf", int'(d0_ovf), 1);
        chk("clrdrop_count", int'(d0_count), 4);

        // Mid-stream asynchronous reset with partial accumulation pending
        d2_fr = 1'b0;
        for (int j = 0; j < 6; j++) begin
            d2_data = 16'hFFFF;
            d2_rdy  = 1'b1;
            tick();
        end
        d2_rdy = 1'b0;
        chk("pre_rst_valid2", int'(d2_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        for (int j = 0; j < 4; j++) begin
            d2_data = 16'h8000 + 16'(j << 4);
            d2_rdy  = 1'b1;
            if (j < 3) tick();
        end
        tick();
        d2_rdy = 1'b0;
        tick();
        chk("post_rst_valid", int'(d2_valid), 1);
        chk("post_rst_sample", int'(d2_sample), 1);
        tick();
        tick();
        chk("post_rst_single", int'(d2_count), 1);
        d2_fr = 1'b1;
        tick();
        d2_fr = 1'b0;
        chk("post_rst_empty", int'(d2_count), 0);

        // Randomized traffic; heavy backpressure first, then balanced
        for (int c = 0; c < 900; c++) begin
            d0_rdy  = ($urandom_range(3) != 0);
            d0_data = 16'($urandom);
            d0_fr   = (c < 300) ? ($urandom_range(3) == 0) : 1'($urandom_range(1));
            d0_clr  = ($urandom_range(15) == 0);
            d2_rdy  = ($urandom_range(3) != 0);
            d2_data = 16'($urandom);
            d2_fr   = (c < 300) ? ($urandom_range(7) == 0) : 1'($urandom_range(1));
            d2_clr  = ($urandom_range(15) == 0);
            tick();
        end
        d0_rdy = 1'b0; d0_clr = 1'b0; d0_fr = 1'b1;
        d2_rdy = 1'b0; d2_clr = 1'b0; d2_fr = 1'b1;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_sample_conditioner.md
# adc_sample_conditioner

Downstream stage of the XADC wrapper: consumes the 16-bit DRP status word and its `drdy` pulse, extracts the 12-bit conversion result, and converts it from offset binary to signed two's complement. It then box-car averages and decimates by 2^DEC_LOG2 and buffers the results in a small show-ahead FIFO. The FIFO drives the FIR filter through a valid/ready handshake. It sits between the ADC block and the FIR/coefficient-control block, in the 78 MHz domain.

## Interface
- `DEC_LOG2`, 2, log2 of averaging/decimation factor; legal values 0..4; 0 = pass-through.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, 2..16.
- `clk_78MHz_i`  in  1  sole clock; all logic is rising-edge.
- `reset_i`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `adc_data_i`  in  16  DRP `do_out` word; result in bits [15:4], bits [3:0] ignored.
- `adc_ready_i`  in  1  DRP `drdy` pulse; `adc_data_i` is valid in the same cycle.
- `fir_ready_i`  in  1  FIR accepts the head sample this cycle.
- `clear_i`  in  1  synchronous clear of `overflow_o`.
- `sample_o`  out  12  signed averaged sample (FIFO head).
- `valid_o`  out  1  FIFO not empty.
- `count_o`  out  $clog2(FIFO_DEPTH)+1  FIFO fill level.
- `overflow_o`  out  1  sticky; set when a result is dropped because the FIFO is full.

## Operation
- **Capture (stage 1).** On `adc_ready_i`=1, register `x = {~adc_data_i[15], adc_data_i[14:4]}` as a signed 12-bit value, and register a capture strobe.
- **Accumulate (stage 2).**
  - Signed accumulator `acc` is 12+DEC_LOG2 bits wide and cannot overflow.
  - Phase counter `ph` is DEC_LOG2 bits wide.
  - On a capture strobe with `ph` < 2^DEC_LOG2−1: `acc <= acc + x`, `ph <= ph+1`.
  - On a capture strobe with `ph` = 2^DEC_LOG2−1: push `(acc + x) >>> DEC_LOG2` (arithmetic shift, floor rounding, low 12 bits) into the FIFO; set `acc <= 0`, `ph <= 0`.
  - With DEC_LOG2=0, every capture is pushed.
- **FIFO.**
  - Show-ahead: `sample_o` = head entry, `valid_o` = (count ≠ 0).
  - Pop occurs when `valid_o && fir_ready_i`.
  - `sample_o` is undefined (implementation holds the last value) while `valid_o`=0. The FIR side must ignore it.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **Boundary rules.**
  - Push while full with no pop in the same cycle: the new result is dropped, the FIFO is unchanged, and `overflow_o` <= 1.
  - Push while full with a pop in the same cycle: both happen, count is unchanged, no overflow.
  - Push while empty: `valid_o` rises the next cycle. Same-cycle bypass is not supported.
  - Pop while empty: ignored.
  - `clear_i` together with an overflow event in the same cycle: `overflow_o` ends at 1 (the set wins).
  - `adc_ready_i` on consecutive cycles must be supported at full rate.
- **Reset (`reset_i`=0, any time).**
  - Cleared: stage-1 registers, `acc`, `ph`, FIFO pointers, count, `overflow_o`.
  - Outputs: `sample_o`=0, `valid_o`=0, `count_o`=0, `overflow_o`=0.
  - Any partial accumulation is discarded.
  - The first result after release uses 2^DEC_LOG2 fresh samples.

## Timing
- Cycle t: final `adc_ready_i` of a group.
- Edge t/t+1: x registered.
- Edge t+1/t+2: FIFO written.
- Result: `valid_o`=1 and `sample_o` = result in cycle t+2 when the FIFO was empty. Latency is 2 cycles.
- `count_o` updates on the same edge as the push or pop.
- Pop at cycle c: the next entry is on `sample_o` in c+1.
- Throughput: one capture per cycle; one output per 2^DEC_LOG2 captures.

## Test plan
- **Reset values:** assert `reset_i`=0 mid-stream → all outputs 0 asynchronously (checked before the next clock edge). Release and feed 4 samples (DEC_LOG2=2) → exactly one output, computed from post-reset samples only.
- **Code conversion, DEC_LOG2=0:**
  - `adc_data_i`=16'h0000 → `sample_o`=12'h800 (−2048).
  - 16'h8000 → 0.
  - 16'hFFFF → 12'h7FF.
  - Each `valid_o` arrives 2 cycles after its `adc_ready_i`.
- **Averaging, DEC_LOG2=2:**
  - Inputs 16'h8000, 8010, 8020, 8030 (x = 0,1,2,3) → `sample_o`=1.
  - x = −1,−1,−1,−2 → `sample_o`=−2 (floor rounding).
  - Back-to-back `adc_ready_i` is accepted without loss.
- **Backpressure/overflow, FIFO_DEPTH=4, DEC_LOG2=0:** hold `fir_ready_i`=0 and push 5 samples → `count_o`=4, `overflow_o`=1. Then release → the first four samples come out in order, 1 per cycle, and `count_o` reaches 0.
- **Full with simultaneous push/pop:** with the FIFO full, push on the same cycle as `fir_ready_i`=1 → `count_o` stays 4, `overflow_o` stays 0, and ordering is preserved.
- **Sticky clear:** with `overflow_o`=1, pulse `clear_i` → 0 next cycle. Pulse `clear_i` on the same cycle as a drop → `overflow_o` remains 1.
